// File: rtl/latch_wb_skid_if.sv
// Handshake bundle for the MEM->WB pipeline register.
// "in_*" is the upstream (producer) side and "out_*" is the downstream (consumer) side.
// The slave modport is the register itself. The master modport is whoever drives it.
interface latch_wb_skid_if #(
  parameter int DATA_W = 32,
  parameter int RN_W   = 5
) ();
  logic              in_valid;
  logic              in_ready;
  logic              in_wreg;
  logic [RN_W-1:0]   in_wn;
  logic [DATA_W-1:0] in_res;
  logic              out_valid;
  logic              out_ready;
  logic              out_wreg;
  logic [RN_W-1:0]   out_wn;
  logic [DATA_W-1:0] out_res;

  modport master (
    output in_valid, in_wreg, in_wn, in_res, out_ready,
    input  in_ready, out_valid, out_wreg, out_wn, out_res
  );

  modport slave (
    input  in_valid, in_wreg, in_wn, in_res, out_ready,
    output in_ready, out_valid, out_wreg, out_wn, out_res
  );
endinterface

// File: rtl/latch_wb_skid.sv
// MEM->WB pipeline register with a valid/ready handshake and a 2-entry skid buffer.
// The head slot H drives the outputs. The skid slot S only fills while H is blocked.
// As a result, in_ready comes straight from a flop and has no combinational path from out_ready.
// Optional feature: define LATCH_WB_STALL_CNT_EN to add a saturating stall-cycle counter on stall_cnt.
module latch_wb_skid #(
  parameter int DATA_W = 32,
  parameter int RN_W   = 5
`ifdef LATCH_WB_STALL_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             flush,
  latch_wb_skid_if.slave   bus
`ifdef LATCH_WB_STALL_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt
`endif
);

  // Occupancy encoding. TWO means the skid slot holds the younger entry.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              in_ready_q;

  logic              h_wreg_q, h_wreg_d;
  logic [RN_W-1:0]   h_wn_q,   h_wn_d;
  logic [DATA_W-1:0] h_res_q,  h_res_d;

  logic              s_wreg_q, s_wreg_d;
  logic [RN_W-1:0]   s_wn_q,   s_wn_d;
  logic [DATA_W-1:0] s_res_q,  s_res_d;

  logic              out_valid;
  logic              acc;
  logic              pop;

  assign out_valid = (state_q != ST_EMPTY);
  assign acc       = bus.in_valid & in_ready_q;
  assign pop       = out_valid & bus.out_ready;

  // Next occupancy and slot loads. Flush wins and loads nothing, so a squashed
  // offer never leaks onto out_wn/out_res.
  always_comb begin
    state_d  = state_q;
    h_wreg_d = h_wreg_q;
    h_wn_d   = h_wn_q;
    h_res_d  = h_res_q;
    s_wreg_d = s_wreg_q;
    s_wn_d   = s_wn_q;
    s_res_d  = s_res_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d  = ST_ONE;
            h_wreg_d = bus.in_wreg;
            h_wn_d   = bus.in_wn;
            h_res_d  = bus.in_res;
          end
        end
        ST_ONE: begin
          if (acc && pop) begin
            h_wreg_d = bus.in_wreg;
            h_wn_d   = bus.in_wn;
            h_res_d  = bus.in_res;
          end else if (acc) begin
            state_d  = ST_TWO;
            s_wreg_d = bus.in_wreg;
            s_wn_d   = bus.in_wn;
            s_res_d  = bus.in_res;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only a pop can move the state.
          if (pop) begin
            state_d  = ST_ONE;
            h_wreg_d = s_wreg_q;
            h_wn_d   = s_wn_q;
            h_res_d  = s_res_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Occupancy, registered ready and both storage slots.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      h_wreg_q   <= 1'b0;
      h_wn_q     <= '0;
      h_res_q    <= '0;
      s_wreg_q   <= 1'b0;
      s_wn_q     <= '0;
      s_res_q    <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_TWO);
      h_wreg_q   <= h_wreg_d;
      h_wn_q     <= h_wn_d;
      h_res_q    <= h_res_d;
      s_wreg_q   <= s_wreg_d;
      s_wn_q     <= s_wn_d;
      s_res_q    <= s_res_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid;
  assign bus.out_wreg  = out_valid & h_wreg_q;
  assign bus.out_wn    = h_wn_q;
  assign bus.out_res   = h_res_q;

`ifdef LATCH_WB_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // Count cycles where the head is valid but not consumed. The counter saturates,
  // and only clr clears it.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !bus.out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
